// File: rtl/uart_pkg.sv
// uart_pkg: constants and the state encoding shared by the UART transmit
// framer and the receive control unit.
//   DATA_W           : bits per character
//   BIT_CNT_W        : width of the per-character bit counter
//   UART_HEADER_BYTE : first byte of every command frame ('R')
//   ST_*             : framer states, 3-bit encoding kept stable for legacy tools
package uart_pkg;

  localparam int DATA_W    = 8;
  localparam int BIT_CNT_W = $clog2(DATA_W);

  localparam logic [DATA_W-1:0] UART_HEADER_BYTE = 8'h52;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Only 1 and 2 stop bits are meaningful; anything else falls back to 1.
  function automatic logic [1:0] stop_preset(input int stop_bits);
    return (stop_bits == 2) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: LSB-first character shift register with bit counter.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_data and clear the bit counter
//   load_data : character to send
//   shift     : move to the next bit (shift right, count up)
//   bit_out   : bit currently on the line during the data phase
//   last_bit  : the counter is at the final data bit
module uart_tx_shifter
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  output logic              bit_out,
  output logic              last_bit
);

  logic [DATA_W-1:0]    sr;
  logic [BIT_CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= load_data;
      cnt <= '0;
    end else if (shift) begin
      // Fill with ones so an over-shifted register still reads as line idle.
      sr  <= {1'b1, sr[DATA_W-1:1]};
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_out  = sr[0];
  assign last_bit = (cnt == BIT_CNT_W'(DATA_W - 1));

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: transmit framer for the receive control unit command frame.
// Sends HEADER then the payload byte (or just the payload), 8 data bits LSB
// first, 1 or 2 stop bits, one bit per tx_clk_bps tick.
//   clk, rst    : clock, asynchronous active-high reset
//   tx_req      : transmit request, accepted when tx_ready is high
//   tx_data     : payload byte, captured at acceptance
//   tx_ready    : high only in IDLE
//   tx_band_sig : baud generator enable, high for the whole frame
//   tx_clk_bps  : end-of-bit tick from the baud generator
//   tx_pin_out  : serial line, idle high
//   tx_done_sig : one-cycle pulse at frame completion
// Build option: define UART_TX_HEADER_EN to send the header byte first;
// undefined, a single payload byte is sent and no byte index exists.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter logic [DATA_W-1:0] HEADER    = UART_HEADER_BYTE,
  parameter int                STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_req,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_band_sig,
  input  logic              tx_clk_bps,
  output logic              tx_pin_out,
  output logic              tx_done_sig
);

  localparam logic [1:0] STOP_PRESET = stop_preset(STOP_BITS);

`ifdef UART_TX_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  state_t            state;
  logic [1:0]        stop_cnt;
  logic              load;
  logic              shift;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] first_byte;
  logic              bit_out;
  logic              last_bit;
  logic              last_stop;
  logic              more_bytes;

  assign first_byte = HDR_EN ? HEADER : tx_data;
  assign last_stop  = (state == ST_STOP) && tx_clk_bps && (stop_cnt == 2'd1);

`ifdef UART_TX_HEADER_EN
  logic [DATA_W-1:0] payload;
  logic              byte_idx;

  assign more_bytes = ~byte_idx;

  // Payload is captured at acceptance so later tx_data changes cannot leak
  // into the second byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      payload  <= '0;
      byte_idx <= 1'b0;
    end else if (state == ST_IDLE && tx_req) begin
      payload  <= tx_data;
      byte_idx <= 1'b0;
    end else if (last_stop && !byte_idx) begin
      byte_idx <= 1'b1;
    end
  end
`else
  assign more_bytes = 1'b0;
`endif

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    load      = 1'b0;
    shift     = 1'b0;
    load_data = first_byte;
    case (state)
      ST_IDLE: load  = tx_req;
      ST_DATA: shift = tx_clk_bps;
`ifdef UART_TX_HEADER_EN
      ST_STOP: begin
        if (last_stop && more_bytes) begin
          load      = 1'b1;
          load_data = payload;
        end
      end
`endif
      default: ;
    endcase
  end

  uart_tx_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .shift     (shift),
    .bit_out   (bit_out),
    .last_bit  (last_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      stop_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (tx_req) state <= ST_START;
        ST_START: if (tx_clk_bps) state <= ST_DATA;
        ST_DATA: begin
          if (tx_clk_bps && last_bit) begin
            state    <= ST_STOP;
            stop_cnt <= STOP_PRESET;
          end
        end
        ST_STOP: begin
          if (tx_clk_bps) begin
            stop_cnt <= stop_cnt - 2'd1;
            if (stop_cnt == 2'd1) state <= more_bytes ? ST_START : ST_DONE;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; the async reset forces IDLE, which
  // drives the line high immediately.
  assign tx_ready    = (state == ST_IDLE);
  assign tx_done_sig = (state == ST_DONE);
  assign tx_band_sig = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
  assign tx_pin_out  = (state == ST_START) ? 1'b0 :
                       (state == ST_DATA)  ? bit_out : 1'b1;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed bench for uart_frame_tx with one instance per
// stop-bit setting; expected line sequences are written out by hand, in
// transmission order, most significant literal bit first.
module tb_uart_frame_tx;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:1]       req = '0;
  logic [2:1][7:0]  data = '0;
  logic [2:1]       tck = '0;
  wire  [2:1]       pin;
  wire  [2:1]       band;
  wire  [2:1]       ready;
  wire  [2:1]       done;

  int total = 0;
  int bad   = 0;
  int done_cnt [1:2];

  always #5 clk = ~clk;

  uart_frame_tx #(.STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .tx_req(req[1]), .tx_data(data[1]), .tx_ready(ready[1]),
    .tx_band_sig(band[1]), .tx_clk_bps(tck[1]), .tx_pin_out(pin[1]), .tx_done_sig(done[1])
  );

  uart_frame_tx #(.STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_req(req[2]), .tx_data(data[2]), .tx_ready(ready[2]),
    .tx_band_sig(band[2]), .tx_clk_bps(tck[2]), .tx_pin_out(pin[2]), .tx_done_sig(done[2])
  );

  initial begin
    done_cnt[1] = 0;
    done_cnt[2] = 0;
  end

  always @(negedge clk) begin
    if (done[1]) done_cnt[1] <= done_cnt[1] + 1;
    if (done[2]) done_cnt[2] <= done_cnt[2] + 1;
  end

  typedef struct {
    int          sel;
    logic [7:0]  d;
    int          len;
    logic [31:0] exp;
    bit          poke;
  } vec_t;

  vec_t vecs [4];

`ifdef UART_TX_HEADER_EN
  localparam int MID_TICKS = 14;
`else
  localparam int MID_TICKS = 5;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic issue_tick(input int sel);
    repeat (15) @(negedge clk);
    tck[sel] = 1'b1;
    @(negedge clk);
    tck[sel] = 1'b0;
  endtask

  // Drives ticks every 16 clk while the enable is high and records the line
  // value of each bit period. Bounded so a stuck DUT cannot hang the run.
  task automatic tick_loop(input int sel, input int len, input bit poke,
                           input logic [7:0] keep, output logic [31:0] got,
                           output int ticks, output bit rdy_bad);
    got = '0;
    ticks = 0;
    rdy_bad = 1'b0;
    while (band[sel] && ticks < 40) begin
      if (ticks < len) got[len-1-ticks] = pin[sel];
      for (int c = 0; c < 15; c++) begin
        if (poke && ticks == 3 && c == 4) begin
          req[sel] = 1'b1;
          data[sel] = 8'h3C;
        end else if (poke && ticks == 3 && c == 5) begin
          req[sel] = 1'b0;
          data[sel] = keep;
        end
        @(negedge clk);
        if (ready[sel]) rdy_bad = 1'b1;
      end
      tck[sel] = 1'b1;
      @(negedge clk);
      tck[sel] = 1'b0;
      ticks++;
    end
  endtask

  task automatic run_frame(input int sel, input logic [7:0] d, input int len,
                           input logic [31:0] exp, input bit poke, input bit hold,
                           input string tag);
    logic [31:0] got;
    int          ticks;
    bit          rb;
    int          d0;
    d0 = done_cnt[sel];
    @(negedge clk);
    req[sel] = 1'b1;
    data[sel] = d;
    @(negedge clk);
    if (!hold) begin
      req[sel] = 1'b0;
      data[sel] = ~d;
    end
    check({tag, "_accept"}, {band[sel], ready[sel], pin[sel]}, 3'b100);
    tick_loop(sel, len, poke, hold ? d : ~d, got, ticks, rb);
    check({tag, "_line"}, got, exp);
    check({tag, "_ticks"}, ticks, len);
    check({tag, "_done_edge"}, {done[sel], band[sel], pin[sel]}, 3'b101);
    check({tag, "_ready_busy"}, rb, 1'b0);
    @(negedge clk);
    check({tag, "_idle"}, {ready[sel], done[sel], pin[sel]}, 3'b101);
    check({tag, "_done_count"}, done_cnt[sel] - d0, 1);
  endtask

  initial begin
    logic [31:0] got;
    int          ticks;
    bit          rb;
    int          d0;
    bit          stray_bad;

`ifdef UART_TX_HEADER_EN
    vecs[0] = '{1, 8'hA5, 20, 32'(20'b0_01001010_1_0_10100101_1), 1'b1};
    vecs[1] = '{2, 8'h00, 22, 32'(22'b0_01001010_11_0_00000000_11), 1'b0};
    vecs[2] = '{1, 8'h3C, 20, 32'(20'b0_01001010_1_0_00111100_1), 1'b0};
    vecs[3] = '{2, 8'hFF, 22, 32'(22'b0_01001010_11_0_11111111_11), 1'b0};
`else
    vecs[0] = '{1, 8'h52, 10, 32'(10'b0_01001010_1), 1'b1};
    vecs[1] = '{2, 8'h00, 11, 32'(11'b0_00000000_11), 1'b0};
    vecs[2] = '{1, 8'hA5, 10, 32'(10'b0_10100101_1), 1'b0};
    vecs[3] = '{2, 8'h3C, 11, 32'(11'b0_00111100_11), 1'b0};
`endif

    // Reset state, both while held and after release.
    repeat (2) @(negedge clk);
    check("reset_held_1", {pin[1], ready[1], band[1], done[1]}, 4'b1100);
    check("reset_held_2", {pin[2], ready[2], band[2], done[2]}, 4'b1100);
    rst = 1'b0;
    @(negedge clk);
    check("reset_rel_1", {pin[1], ready[1], band[1], done[1]}, 4'b1100);

    // Stray ticks while idle must not start anything.
    stray_bad = 1'b0;
    d0 = done_cnt[1];
    for (int i = 0; i < 5; i++) begin
      tck = 2'b11;
      @(negedge clk);
      tck = 2'b00;
      if (!pin[1] || !ready[1] || band[1] || !pin[2] || !ready[2] || band[2]) stray_bad = 1'b1;
      @(negedge clk);
      if (!pin[1] || !ready[1] || band[1] || !pin[2] || !ready[2] || band[2]) stray_bad = 1'b1;
    end
    check("stray_ticks_idle", stray_bad, 1'b0);
    check("stray_ticks_no_done", done_cnt[1] - d0, 0);

    // Table-driven frames; vector 0 also pokes a busy request mid-byte.
    for (int i = 0; i < 4; i++)
      run_frame(vecs[i].sel, vecs[i].d, vecs[i].len, vecs[i].exp, vecs[i].poke, 1'b0,
                $sformatf("vec%0d", i));

    // Request held high: the next frame starts after exactly two idle cycles.
    run_frame(1, vecs[0].d, vecs[0].len, vecs[0].exp, 1'b0, 1'b1, "held1");
    @(negedge clk);
    check("held_restart", {pin[1], band[1]}, 2'b01);
    req[1] = 1'b0;
    data[1] = 8'h00;
    d0 = done_cnt[1];
    tick_loop(1, vecs[0].len, 1'b0, 8'h00, got, ticks, rb);
    check("held2_line", got, vecs[0].exp);
    check("held2_ticks", ticks, vecs[0].len);
    @(negedge clk);
    check("held2_done_count", done_cnt[1] - d0, 1);

    // Reset mid-payload aborts at once without a done pulse.
    @(negedge clk);
    req[1] = 1'b1;
    data[1] = 8'hA5;
    @(negedge clk);
    req[1] = 1'b0;
    d0 = done_cnt[1];
    repeat (MID_TICKS) issue_tick(1);
    check("midframe_busy", band[1], 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midreset_async", {pin[1], band[1], ready[1]}, 3'b101);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_no_done", done_cnt[1] - d0, 0);
    run_frame(1, vecs[2].d, vecs[2].len, vecs[2].exp, 1'b0, 1'b0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
